// File: rtl/counter_ctrl_pkg.sv
// Shared state encodings and defaults for the counter sequencing controller.
package counter_ctrl_pkg;
  localparam int STATE_W      = 2;
  localparam int PRESCALE_DEF = 4;
  localparam int SCAN_DIV_DEF = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Width of a modulo-n counter; a divide-by-1 still needs one bit to exist.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/counter_ctrl_rise_pulse.sv
// Rising-edge detector: one registered pulse per low-to-high transition of a level command.
module rise_pulse (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);
  logic prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      prev  <= level;
      pulse <= level & ~prev;
    end
  end
endmodule

// File: rtl/counter_ctrl.sv
// Start/stop/clr sequencer driving prescaled counter enables, a limit stop and the LED byte select.
// Define COUNTER_CTRL_AUTOSCAN_EN to rotate sel automatically instead of following sel_in.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEF,
  parameter int SCAN_DIV = SCAN_DIV_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               clr,
  input  logic [31:0]        limit,
  input  logic [31:0]        count,
  input  logic [1:0]         sel_in,
  output logic               cnt_en,
  output logic               cnt_clr,
  output logic [1:0]         sel,
  output logic               done,
  output logic               busy,
  output logic [STATE_W-1:0] state
);
  localparam int            PW       = cnt_width(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  state_t        st;
  logic [PW-1:0] presc;
  logic          start_p, stop_p, clr_p;

  rise_pulse u_start (.clk(clk), .rst(rst), .level(start), .pulse(start_p));
  rise_pulse u_stop  (.clk(clk), .rst(rst), .level(stop),  .pulse(stop_p));
  rise_pulse u_clr   (.clk(clk), .rst(rst), .level(clr),   .pulse(clr_p));

  assign state = st;

  // The stop cycle still counts as a RUN cycle, so a pause resumes on the same phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st      <= ST_IDLE;
      presc   <= '0;
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
      if (clr_p) begin
        st      <= ST_IDLE;
        presc   <= '0;
        cnt_clr <= 1'b1;
        busy    <= 1'b0;
        done    <= 1'b0;
      end else begin
        case (st)
          ST_IDLE, ST_PAUSE: begin
            if (start_p && !stop_p) begin
              st   <= ST_RUN;
              busy <= 1'b1;
            end
          end
          ST_RUN: begin
            if (count == limit) begin
              st    <= ST_DONE;
              presc <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              if (presc == PRE_LAST) begin
                presc  <= '0;
                cnt_en <= 1'b1;
              end else begin
                presc <= presc + PW'(1);
              end
              if (stop_p) begin
                st   <= ST_PAUSE;
                busy <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef COUNTER_CTRL_AUTOSCAN_EN
  localparam int            SW        = cnt_width(SCAN_DIV);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  logic [SW-1:0] scan;
  logic [1:0]    unused_sel_in;
  assign unused_sel_in = sel_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan <= '0;
      sel  <= 2'd0;
    end else if (scan == SCAN_LAST) begin
      scan <= '0;
      sel  <= sel + 2'd1;
    end else begin
      scan <= scan + SW'(1);
    end
  end
`else
  localparam int unused_scan_div = SCAN_DIV;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sel <= 2'd0;
    else      sel <= sel_in;
  end
`endif
endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl with a behavioural 32-bit counter closing the feedback loop.
module tb_counter_ctrl;
  import counter_ctrl_pkg::*;

  localparam int P  = 4;
  localparam int SD = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, clr = 1'b0;
  logic [31:0] limit = 32'd0;
  logic [31:0] cnt;
  logic [1:0]  sel_in = 2'd0;
  logic        cnt_en, cnt_clr, done, busy;
  logic [1:0]  sel, state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // The counter being sequenced.
  always @(posedge clk or negedge rst) begin
    if (!rst)         cnt <= 32'd0;
    else if (cnt_clr) cnt <= 32'd0;
    else if (cnt_en)  cnt <= cnt + 32'd1;
  end

  counter_ctrl #(.PRESCALE(P), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr),
    .limit(limit), .count(cnt), .sel_in(sel_in),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr), .sel(sel),
    .done(done), .busy(busy), .state(state)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({cnt_en, cnt_clr, sel, done, busy, state} !== 8'h00) begin
      errors++; $display("FAIL reset_outputs: got %h expected 00", {cnt_en, cnt_clr, sel, done, busy, state});
    end
    tick; tick;
    rst = 1'b1;
    tick;
    checks++;
    if (state !== ST_IDLE || busy !== 1'b0) begin
      errors++; $display("FAIL reset_release: state %0d busy %0d expected 0 0", state, busy);
    end
  endtask

  task automatic test_count;
    int b, e, dcyc;
    exp_q.delete();
    limit = 32'd5;
    start = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_early: got %0d expected 0", busy); end
    tick;
    b = cyc;
    checks++;
    if (busy !== 1'b1 || state !== ST_RUN) begin
      errors++; $display("FAIL busy_latency: busy %0d state %0d expected 1 1", busy, state);
    end
    for (int k = 1; k <= 5; k++) exp_q.push_back(b + P * k);
    dcyc = -1;
    repeat (40) begin
      tick;
      if (cnt_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL cnt_en_extra: got pulse at cycle %0d expected none", cyc - b);
        end else begin
          e = exp_q.pop_front();
          if (cyc !== e) begin errors++; $display("FAIL cnt_en_time: got cycle %0d expected %0d", cyc - b, e - b); end
        end
      end
      if (done && dcyc < 0) dcyc = cyc;
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL cnt_en_missing: got %0d left expected 0", exp_q.size()); end
    checks++;
    if (dcyc !== b + 5 * P + 2) begin errors++; $display("FAIL done_time: got %0d expected %0d", dcyc - b, 5 * P + 2); end
    checks++;
    if (cnt !== 32'd5 || state !== ST_DONE) begin
      errors++; $display("FAIL done_state: count %0d state %0d expected 5 3", cnt, state);
    end
  endtask

  task automatic test_hold_pause;
    int entries, gap, ngap;
    logic [1:0] prev;
    logic got, paused;
    clr = 1'b1; tick; clr = 1'b0; tick; tick;
    limit = 32'hFFFF_FFF0;
    start = 1'b1;
    entries = 0;
    prev = state;
    repeat (20) begin
      tick;
      if (state == ST_RUN && prev != ST_RUN) entries++;
      prev = state;
    end
    start = 1'b0;
    checks++;
    if (entries !== 1) begin errors++; $display("FAIL hold_entries: got %0d expected 1", entries); end
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (cnt_en) begin got = 1'b1; break; end
    end
    checks++;
    if (!got) begin errors++; $display("FAIL run_cnt_en: got 0 expected 1"); end
    gap = 0; ngap = 0; paused = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (busy) gap++;
      if (state == ST_PAUSE) begin
        paused = 1'b1;
        checks++;
        if (cnt_en !== 1'b0) begin errors++; $display("FAIL pause_cnt_en: got 1 expected 0"); end
      end
      if (cnt_en) begin
        ngap++;
        checks++;
        if (gap !== P) begin errors++; $display("FAIL phase_gap: got %0d expected %0d", gap, P); end
        gap = 0;
      end
      if (i == 2)  stop = 1'b1;
      if (i == 3)  stop = 1'b0;
      if (i == 15) start = 1'b1;
      if (i == 16) start = 1'b0;
    end
    checks++;
    if (!paused || ngap < 3) begin errors++; $display("FAIL pause_seen: paused %0d gaps %0d expected 1 >=3", paused, ngap); end
  endtask

  task automatic test_priority;
    clr = 1'b1; stop = 1'b1; start = 1'b1;
    tick;
    checks++;
    if (state !== ST_RUN || cnt_clr !== 1'b0) begin
      errors++; $display("FAIL prio_pre: state %0d cnt_clr %0d expected 1 0", state, cnt_clr);
    end
    tick;
    checks++;
    if (cnt_clr !== 1'b1 || state !== ST_IDLE || busy !== 1'b0) begin
      errors++; $display("FAIL prio_clr: cnt_clr %0d state %0d busy %0d expected 1 0 0", cnt_clr, state, busy);
    end
    tick;
    checks++;
    if (cnt_clr !== 1'b0 || state !== ST_IDLE) begin
      errors++; $display("FAIL prio_after: cnt_clr %0d state %0d expected 0 0", cnt_clr, state);
    end
    clr = 1'b0; stop = 1'b0; start = 1'b0;
    tick;
  endtask

  task automatic test_limit_zero;
    int ens;
    limit = 32'd0;
    ens = 0;
    start = 1'b1; tick; start = 1'b0;
    tick;
    if (cnt_en) ens++;
    checks++;
    if (state !== ST_RUN || busy !== 1'b1) begin
      errors++; $display("FAIL lz_run: state %0d busy %0d expected 1 1", state, busy);
    end
    tick;
    if (cnt_en) ens++;
    checks++;
    if (state !== ST_DONE || done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL lz_done: state %0d done %0d busy %0d expected 3 1 0", state, done, busy);
    end
    start = 1'b1; tick; start = 1'b0;
    stop = 1'b1; tick; stop = 1'b0;
    repeat (6) begin tick; if (cnt_en) ens++; end
    checks++;
    if (ens !== 0) begin errors++; $display("FAIL lz_cnt_en: got %0d expected 0", ens); end
    checks++;
    if (state !== ST_DONE) begin errors++; $display("FAIL lz_stay_done: got %0d expected 3", state); end
    clr = 1'b1; tick; clr = 1'b0; tick;
    checks++;
    if (cnt_clr !== 1'b1 || state !== ST_IDLE || done !== 1'b0) begin
      errors++; $display("FAIL lz_clr: cnt_clr %0d state %0d done %0d expected 1 0 0", cnt_clr, state, done);
    end
    tick;
  endtask

  task automatic test_reset_mid_run;
    logic got;
    int ens;
    limit = 32'hFFFF_FFF0;
    start = 1'b1; tick; start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (cnt_en) begin got = 1'b1; break; end
    end
    checks++;
    if (!got || busy !== 1'b1) begin errors++; $display("FAIL rst_prep: cnt_en %0d busy %0d expected 1 1", got, busy); end
    rst = 1'b0;
    #1;
    checks++;
    if ({cnt_en, cnt_clr, sel, done, busy, state} !== 8'h00) begin
      errors++; $display("FAIL rst_async: got %h expected 00", {cnt_en, cnt_clr, sel, done, busy, state});
    end
    #2 rst = 1'b1;
    ens = 0;
    repeat (8) begin tick; if (cnt_en || state != ST_IDLE) ens++; end
    checks++;
    if (ens !== 0) begin errors++; $display("FAIL rst_idle: got %0d active cycles expected 0", ens); end
  endtask

  task automatic test_sel;
    int e;
    logic [1:0] v;
    exp_q.delete();
`ifdef COUNTER_CTRL_AUTOSCAN_EN
    rst = 1'b0;
    #1 rst = 1'b1;
    for (int n = 1; n <= 5 * SD; n++) exp_q.push_back((n / SD) % 4);
    repeat (5 * SD) begin
      tick;
      e = exp_q.pop_front();
      v = 2'(e);
      sel_in = 2'($urandom_range(0, 3));
      checks++;
      if (sel !== v) begin errors++; $display("FAIL autoscan_sel: got %0d expected %0d at cycle %0d", sel, v, cyc); end
    end
`else
    sel_in = 2'd2;
    exp_q.push_back(2);
    #1;
    checks++;
    if (sel === 2'd2) begin errors++; $display("FAIL sel_early: got 2 expected previous value"); end
    for (int i = 0; i < 20; i++) begin
      tick;
      e = exp_q.pop_front();
      v = 2'(e);
      checks++;
      if (sel !== v) begin errors++; $display("FAIL sel_follow: got %0d expected %0d", sel, v); end
      v = 2'($urandom_range(0, 3));
      sel_in = v;
      exp_q.push_back(int'(v));
    end
    tick;
    e = exp_q.pop_front();
    v = 2'(e);
    checks++;
    if (sel !== v) begin errors++; $display("FAIL sel_follow: got %0d expected %0d", sel, v); end
`endif
  endtask

  initial begin
    test_reset();
    test_count();
    test_hold_pause();
    test_priority();
    test_limit_zero();
    test_reset_mid_run();
    test_sel();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Sequencing controller for the 32-bit free-running counter datapath. Converts raw start/stop/clear commands into a counter enable stream with a programmable prescaler, stops the count at a programmable limit, and drives the 2-bit byte select that picks which counter byte reaches the 8 board LEDs. Sits between the board switches/buttons and the counter; the counter's `q` feeds back into `count`.

## Interface
- `PRESCALE`, 4: clk cycles per counter increment (≥1); board builds override to 50_000_000.
- `SCAN_DIV`, 8: clk cycles per byte-select step in autoscan mode (≥1).
- `clk` input 1: system clock, all state on rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `start` input 1: level command; rising edge requests run.
- `stop` input 1: level command; rising edge requests pause.
- `clr` input 1: level command; rising edge requests clear.
- `limit` input 32: terminal count value.
- `count` input 32: current counter value, fed back from the counter.
- `sel_in` input 2: manual byte select.
- `cnt_en` output 1: one-cycle increment enable to the counter.
- `cnt_clr` output 1: one-cycle synchronous clear to the counter.
- `sel` output 2: byte select to the counter's LED mux.
- `done` output 1: high while in DONE.
- `busy` output 1: high while in RUN.
- `state` output 2: encoded FSM state.

## Operation
- Commands: each of `start`/`stop`/`clr` registered once; pulse = current & ~previous. Held levels produce one pulse only.
- Priority on same-cycle pulses: clr > stop > start.
- States: IDLE=0, RUN=1, PAUSE=2, DONE=3.
- IDLE: start → RUN. stop ignored.
- RUN: prescaler counts 0..PRESCALE-1; at PRESCALE-1 it wraps and `cnt_en` pulses. stop → PAUSE. start ignored.
- RUN limit check every cycle: `count == limit` → DONE, `cnt_en` forced 0 that cycle; prescaler cleared.
- PAUSE: prescaler frozen (resumes same phase). start → RUN.
- DONE: start/stop ignored; only clr leaves.
- clr in any state: `cnt_clr` pulses one cycle, prescaler cleared, next state IDLE.
- `limit == 0` with `count == 0`: start → RUN for one cycle → DONE, zero increments.
- `limit` changed mid-RUN below `count`: no match until counter wraps 0xFFFFFFFF→0; controller does not detect overrun.
- All outputs registered.

## Timing
- Reset (rst=0, async): state=IDLE, prescaler=0, scan counter=0, `cnt_en`=0, `cnt_clr`=0, `sel`=0, `done`=0, `busy`=0, `state`=0. Reset mid-RUN aborts immediately, no `cnt_en` glitch.
- Command latency: level rises before edge k → pulse internal after edge k → `state`/`busy` update after edge k+1.
- First `cnt_en` asserts PRESCALE cycles after `busy` rises; thereafter every PRESCALE cycles, exactly one cycle wide.
- `cnt_clr` asserts one cycle after the clr pulse, same edge as `state`→IDLE.
- DONE entry: `done` high the edge after `count == limit` is sampled.

## Configuration
- `COUNTER_CTRL_AUTOSCAN_EN` defined: `sel` increments every SCAN_DIV clk cycles in every state, wraps 3→0; `sel_in` ignored.
- Undefined: `sel` = `sel_in` registered (one-cycle latency); scan counter not built.

## Structure
- Package `counter_ctrl_pkg`: state encodings (IDLE/RUN/PAUSE/DONE), state width constant, default PRESCALE/SCAN_DIV values.
- One sub-module: `rise_pulse` (register + AND-NOT edge detector), instantiated three times for start/stop/clr.

## Test plan
- Reset, PRESCALE=4, limit=5, start pulse → `busy` 2 cycles later, `cnt_en` every 4th cycle, `done` after 5 increments, no 6th `cnt_en`.
- Start held high 20 cycles → exactly one RUN entry; stop pulse mid-run → PAUSE, `cnt_en` silent; start → resumes, next `cnt_en` keeps pre-pause prescaler phase.
- clr+stop+start same cycle in RUN → `cnt_clr` one cycle, state IDLE.
- limit=0, count=0, start → DONE, zero `cnt_en` pulses; start in DONE ignored; clr → IDLE.
- rst low mid-RUN → all outputs 0 asynchronously (before next clk edge); release → IDLE.
- AUTOSCAN_EN, SCAN_DIV=8 → `sel` 0,1,2,3,0 every 8 cycles; without macro, `sel_in`=2 → `sel`=2 one cycle later.
